// File: rtl/demux_route_if.sv
// Handshake and status bundle between an upstream source, the demux route
// controller and its eight downstream channels.
interface demux_route_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [2:0]    in_dest;
    logic [7:0]    ch_en;
    logic [7:0]    out_ready;
    logic [7:0]    out_valid;
    logic [DW-1:0] out_data;
    logic [2:0]    sel;
    logic          busy;
    logic [7:0]    drop_cnt;

    modport master (
        output in_valid, in_data, in_dest, ch_en, out_ready,
        input  in_ready, out_valid, out_data, sel, busy, drop_cnt
    );

    modport slave (
        input  in_valid, in_data, in_dest, ch_en, out_ready,
        output in_ready, out_valid, out_data, sel, busy, drop_cnt
    );
endinterface

// File: rtl/demux_route_ctrl.sv
// One-word holding demux: routes each accepted word to a single enabled channel,
// dropping words for disabled channels or words that wait too long.
//
//   state | meaning
//   IDLE  | no word held, ready for upstream
//   HOLD  | one word held, strobing its channel until taken or timed out
module demux_route_ctrl #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    demux_route_if.slave    bus
);
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Wait timer is a down-counter; terminal count zero on a non-completing
    // HOLD edge is the TIMEOUT-th cycle of waiting.
    localparam logic [7:0] WAIT_LOAD = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_t        state;
    logic [7:0]    wait_cnt;
    logic [DW-1:0] data_next;
    logic          complete;
    logic          take;
    logic          enabled;
    logic          timeout;

    assign data_next = bus.in_data;

    // sel doubles as the held destination register.
    assign bus.in_ready = rst_n && ((state == IDLE) || bus.out_ready[bus.sel]);

    always_comb begin
        complete = (state == HOLD) && bus.out_ready[bus.sel];
        take     = bus.in_valid && bus.in_ready;
        enabled  = bus.ch_en[bus.in_dest];
        timeout  = (TIMEOUT != 0) && (state == HOLD) && !complete && (wait_cnt == 8'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wait_cnt      <= 8'd0;
            bus.out_valid <= 8'd0;
            bus.out_data  <= '0;
            bus.sel       <= 3'd0;
            bus.busy      <= 1'b0;
            bus.drop_cnt  <= 8'd0;
        end else if (take && enabled) begin
            state         <= HOLD;
            wait_cnt      <= WAIT_LOAD;
            bus.out_valid <= 8'd1 << bus.in_dest;
            bus.out_data  <= data_next;
            bus.sel       <= bus.in_dest;
            bus.busy      <= 1'b1;
        end else if (take || timeout) begin
            // Discarded word: either its channel was disabled at accept or it
            // waited out the timer. Holding registers keep their old contents.
            state         <= IDLE;
            wait_cnt      <= 8'd0;
            bus.out_valid <= 8'd0;
            bus.busy      <= 1'b0;
            if (bus.drop_cnt != 8'hFF) begin
                bus.drop_cnt <= bus.drop_cnt + 8'd1;
            end
        end else if (complete) begin
            state         <= IDLE;
            wait_cnt      <= 8'd0;
            bus.out_valid <= 8'd0;
            bus.busy      <= 1'b0;
        end else if ((state == HOLD) && (wait_cnt != 8'd0)) begin
            wait_cnt <= wait_cnt - 8'd1;
        end
    end
endmodule

// File: tb/tb_demux_route_ctrl.sv
// Scenario bench for demux_route_ctrl: one instance with TIMEOUT=15 carries
// the scoreboard, a second with TIMEOUT=0 checks the never-time-out case.
module tb_demux_route_ctrl;
    localparam int DW = 8;

    typedef struct packed {
        logic [2:0]    dest;
        logic [DW-1:0] data;
    } item_t;

    logic  clk;
    logic  rst_n;
    int    n_cmp;
    int    n_bad;
    item_t exp_q[$];
    item_t mon_e;

    demux_route_if #(.DW(DW)) bus1 ();
    demux_route_if #(.DW(DW)) bus0 ();

    demux_route_ctrl #(.DW(DW), .TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    demux_route_ctrl #(.DW(DW), .TIMEOUT(0)) dut_nt (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: pop on completion, push on accept into an enabled channel.
    always @(negedge clk) begin
        if (rst_n) begin
            if ((bus1.out_valid != 8'd0) && bus1.out_ready[bus1.sel]) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_empty: out_valid=%h sel=%0d data=%h with nothing expected",
                             bus1.out_valid, bus1.sel, bus1.out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus1.sel !== mon_e.dest || bus1.out_data !== mon_e.data ||
                        bus1.out_valid !== (8'd1 << mon_e.dest)) begin
                        n_bad++;
                        $display("FAIL sb_word: got sel=%0d data=%h valid=%h, want sel=%0d data=%h",
                                 bus1.sel, bus1.out_data, bus1.out_valid, mon_e.dest, mon_e.data);
                    end
                end
            end
            if (bus1.in_valid && bus1.in_ready && bus1.ch_en[bus1.in_dest])
                exp_q.push_back({bus1.in_dest, bus1.in_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_dest = 3'd0;
        bus1.ch_en = 8'h00;   bus1.out_ready = 8'h00;
        bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.in_dest = 3'd0;
        bus0.ch_en = 8'h00;   bus0.out_ready = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus1.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", bus1.in_ready); end
        n_cmp++;
        if (bus1.out_valid !== 8'h00 || bus1.busy !== 1'b0) begin
            n_bad++; $display("FAIL rst_valid_busy: got valid=%h busy=%b want 00/0", bus1.out_valid, bus1.busy);
        end
        n_cmp++;
        if (bus1.out_data !== 8'h00 || bus1.sel !== 3'd0 || bus1.drop_cnt !== 8'h00) begin
            n_bad++; $display("FAIL rst_regs: got data=%h sel=%0d drop=%0d want 0/0/0",
                              bus1.out_data, bus1.sel, bus1.drop_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (bus1.in_ready !== 1'b1 || bus1.busy !== 1'b0) begin
            n_bad++; $display("FAIL rst_release: got in_ready=%b busy=%b want 1/0", bus1.in_ready, bus1.busy);
        end
    endtask

    task automatic test_basic();
        bus1.ch_en = 8'hFF; bus1.out_ready = 8'hFF;
        bus1.in_valid = 1'b1; bus1.in_dest = 3'd5; bus1.in_data = 8'hA5;
        @(negedge clk);
        n_cmp++;
        if (bus1.out_valid !== 8'h00) begin n_bad++; $display("FAIL basic_pre: got %h want 00", bus1.out_valid); end
        tick();
        bus1.in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus1.out_valid !== 8'h20 || bus1.sel !== 3'd5 || bus1.out_data !== 8'hA5 || bus1.busy !== 1'b1) begin
            n_bad++; $display("FAIL basic_hold: got valid=%h sel=%0d data=%h busy=%b want 20/5/a5/1",
                              bus1.out_valid, bus1.sel, bus1.out_data, bus1.busy);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (bus1.out_valid !== 8'h00 || bus1.busy !== 1'b0 || bus1.sel !== 3'd5 || bus1.out_data !== 8'hA5) begin
            n_bad++; $display("FAIL basic_idle: got valid=%h busy=%b sel=%0d data=%h want 00/0/5/a5",
                              bus1.out_valid, bus1.busy, bus1.sel, bus1.out_data);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] want;
        bus1.ch_en = 8'hFF; bus1.out_ready = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            bus1.in_valid = 1'b1; bus1.in_dest = 3'(i); bus1.in_data = 8'(8'h30 + i);
            @(negedge clk);
            want = (i == 0) ? 8'h00 : (8'd1 << (i - 1));
            n_cmp++;
            if (bus1.in_ready !== 1'b1 || bus1.out_valid !== want) begin
                n_bad++; $display("FAIL b2b_%0d: got in_ready=%b valid=%h want 1/%h", i, bus1.in_ready, bus1.out_valid, want);
            end
            tick();
        end
        bus1.in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus1.out_valid !== 8'h80) begin n_bad++; $display("FAIL b2b_last: got %h want 80", bus1.out_valid); end
        tick();
        @(negedge clk);
        n_cmp++;
        if (bus1.out_valid !== 8'h00) begin n_bad++; $display("FAIL b2b_idle: got %h want 00", bus1.out_valid); end
        tick();
    endtask

    task automatic test_backpressure();
        bus1.ch_en = 8'hFF; bus1.out_ready = 8'hF7;
        bus1.in_valid = 1'b1; bus1.in_dest = 3'd3; bus1.in_data = 8'h3C;
        tick();
        // Next word waits on the stall; channel 3 is disabled while held.
        bus1.in_dest = 3'd4; bus1.in_data = 8'h44; bus1.ch_en = 8'hF7;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus1.out_valid !== 8'h08 || bus1.in_ready !== 1'b0) begin
                n_bad++; $display("FAIL bp_stall_%0d: got valid=%h in_ready=%b want 08/0", k, bus1.out_valid, bus1.in_ready);
            end
            tick();
        end
        bus1.out_ready = 8'hFF;
        @(negedge clk);
        n_cmp++;
        if (bus1.out_valid !== 8'h08 || bus1.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp_release: got valid=%h in_ready=%b want 08/1", bus1.out_valid, bus1.in_ready);
        end
        tick();
        bus1.in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus1.out_valid !== 8'h10 || bus1.drop_cnt !== 8'h00) begin
            n_bad++; $display("FAIL bp_next: got valid=%h drop=%0d want 10/0", bus1.out_valid, bus1.drop_cnt);
        end
        tick();
        bus1.ch_en = 8'hFF;
        @(negedge clk);
        n_cmp++;
        if (bus1.out_valid !== 8'h00) begin n_bad++; $display("FAIL bp_idle: got %h want 00", bus1.out_valid); end
        tick();
    endtask

    task automatic test_timeout();
        int cnt;
        int cnt0;
        bus1.ch_en = 8'hFF; bus1.out_ready = 8'h00;
        bus1.in_valid = 1'b1; bus1.in_dest = 3'd6; bus1.in_data = 8'h66;
        tick();
        bus1.in_valid = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus1.out_valid != 8'h40) break;
            cnt++;
        end
        n_cmp++;
        if (cnt != 15 || bus1.out_valid !== 8'h00) begin
            n_bad++; $display("FAIL timeout_len: got %0d cycles (valid now %h) want 15 then 00", cnt, bus1.out_valid);
        end
        n_cmp++;
        if (bus1.drop_cnt !== 8'd1) begin n_bad++; $display("FAIL timeout_drop: got %0d want 1", bus1.drop_cnt); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        tick();

        bus0.ch_en = 8'hFF; bus0.out_ready = 8'h00;
        bus0.in_valid = 1'b1; bus0.in_dest = 3'd6; bus0.in_data = 8'h66;
        tick();
        bus0.in_valid = 1'b0;
        cnt0 = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus0.out_valid == 8'h40) cnt0++;
        end
        n_cmp++;
        if (cnt0 != 40 || bus0.drop_cnt !== 8'd0) begin
            n_bad++; $display("FAIL no_timeout: got %0d/40 cycles drop=%0d want 40/0", cnt0, bus0.drop_cnt);
        end
        #1;
        bus0.out_ready = 8'hFF;
        tick();
        @(negedge clk);
        n_cmp++;
        if (bus0.out_valid !== 8'h00) begin n_bad++; $display("FAIL no_timeout_done: got %h want 00", bus0.out_valid); end
        tick();
    endtask

    task automatic test_saturation();
        int seen;
        int want;
        bus1.ch_en = 8'hFE; bus1.out_ready = 8'hFF;
        bus1.in_valid = 1'b1; bus1.in_dest = 3'd0;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            bus1.in_data = 8'(i);
            @(negedge clk);
            if (bus1.out_valid != 8'h00) seen++;
            if (i % 60 == 0 || i == 253 || i == 254) begin
                want = (1 + i > 255) ? 255 : 1 + i;
                n_cmp++;
                if (bus1.drop_cnt !== 8'(want)) begin
                    n_bad++; $display("FAIL sat_cnt_%0d: got %0d want %0d", i, bus1.drop_cnt, want);
                end
            end
            tick();
        end
        bus1.in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus1.drop_cnt !== 8'd255 || seen != 0) begin
            n_bad++; $display("FAIL sat_final: got drop=%0d valid_cycles=%0d want 255/0", bus1.drop_cnt, seen);
        end
        tick();
    endtask

    task automatic test_reset_hold();
        bus1.ch_en = 8'hFF; bus1.out_ready = 8'h00;
        bus1.in_valid = 1'b1; bus1.in_dest = 3'd2; bus1.in_data = 8'h22;
        tick();
        bus1.in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus1.out_valid !== 8'h04) begin n_bad++; $display("FAIL rh_hold: got %h want 04", bus1.out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus1.out_valid !== 8'h00 || bus1.drop_cnt !== 8'h00 || bus1.busy !== 1'b0 || bus1.in_ready !== 1'b0) begin
            n_bad++; $display("FAIL rh_async: got valid=%h drop=%0d busy=%b in_ready=%b want 00/0/0/0",
                              bus1.out_valid, bus1.drop_cnt, bus1.busy, bus1.in_ready);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 8'h00 || bus1.drop_cnt !== 8'h00) begin
            n_bad++; $display("FAIL rh_release: got in_ready=%b valid=%h drop=%0d want 1/00/0",
                              bus1.in_ready, bus1.out_valid, bus1.drop_cnt);
        end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_saturation();
        test_reset_hold();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL sb_leftover: got %0d words outstanding want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/demux_route_ctrl.md
DEMUX_ROUTE_CTRL -- requirements
Module: demux_route_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8: data word width.
REQ-002 SHALL have parameter TIMEOUT, default 15, range 0..255: max cycles a word waits for its channel; 0 = never time out.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream word present.
REQ-006 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port in_data  input  DW  upstream word.
REQ-008 SHALL have port in_dest  input  3  destination channel 0..7.
REQ-009 SHALL have port ch_en  input  8  per-channel enable mask.
REQ-010 SHALL have port out_ready  input  8  per-channel downstream ready.
REQ-011 SHALL have port out_valid  output  8  one-hot channel strobe.
REQ-012 SHALL have port out_data  output  DW  held word, common to all channels.
REQ-013 SHALL have port sel  output  3  demux select {s2,s1,s0}, equal to held destination.
REQ-014 SHALL have port busy  output  1  high in HOLD.
REQ-015 SHALL have port drop_cnt  output  8  count of dropped words, saturating.

Function
REQ-016 SHALL implement a two-state FSM: IDLE (no held word), HOLD (one word held in data/dest registers).
REQ-017 SHALL drive in_ready = 1 in IDLE, and in HOLD only when out_ready[dest_q] = 1; in_ready combinational from out_ready.
REQ-018 SHALL accept a word on any rising edge with in_valid = 1 and in_ready = 1.
REQ-019 SHALL, on accept with ch_en[in_dest] = 1, load in_data/in_dest into holding registers, clear wait counter, enter/stay HOLD.
REQ-020 SHALL, on accept with ch_en[in_dest] = 0, discard the word, increment drop_cnt, go to IDLE (or stay IDLE); the holding register SHALL NOT be loaded.
REQ-021 SHALL, in HOLD, drive out_valid = one-hot(dest_q), sel = dest_q, out_data = data_q, busy = 1; all registered outputs, no combinational path from inputs.
REQ-022 SHALL, in IDLE, drive out_valid = 0; sel and out_data SHALL hold last values.
REQ-023 SHALL complete a transfer on a rising edge in HOLD with out_ready[dest_q] = 1; if no word accepted the same edge, go to IDLE.
REQ-024 SHALL sustain one word per cycle: completion and new accept on the same edge loads the new word, no IDLE bubble.
REQ-025 SHALL ignore out_ready bits of non-selected channels.
REQ-026 SHALL, with TIMEOUT > 0, count HOLD cycles without completion; if out_valid has been high TIMEOUT cycles without out_ready[dest_q], drop the word at the end of the TIMEOUT-th cycle: increment drop_cnt, go IDLE.
REQ-027 SHALL give completion priority over timeout in the same cycle.
REQ-028 SHALL saturate drop_cnt at 255; it SHALL clear only on reset.
REQ-029 SHALL sample ch_en only at accept; ch_en changes during HOLD SHALL NOT affect the held word.
REQ-030 SHALL have accept-to-out_valid latency of exactly 1 cycle.

Reset
REQ-031 SHALL, while rst_n = 0, force IDLE, in_ready = 0, out_valid = 0, out_data = 0, sel = 0, busy = 0, drop_cnt = 0, wait counter = 0, independent of clk.
REQ-032 SHALL, on reset asserted in HOLD, discard the held word without counting a drop.
REQ-033 SHALL, on first rising edge after rst_n deasserts, be in IDLE with in_ready = 1.

Verification
REQ-034 SHALL cover basic route: ch_en=FF, in_dest=5, in_data=A5, out_ready=FF -> next cycle out_valid=20, sel=5, out_data=A5; IDLE one cycle later.
REQ-035 SHALL cover back-to-back: dests 0,1,2,...,7 on consecutive cycles, out_ready=FF -> out_valid 01,02,04,...,80 on consecutive cycles, in_ready constant 1.
REQ-036 SHALL cover backpressure: dest=3, out_ready[3]=0 for 4 cycles then 1, TIMEOUT=15 -> out_valid=08 held 5 cycles, in_ready=0 first 4 of them, drop_cnt=0.
REQ-037 SHALL cover timeout: dest=6, out_ready=00, TIMEOUT=15 -> out_valid=40 exactly 15 cycles, then 00, drop_cnt=1; with TIMEOUT=0 out_valid stays 40 indefinitely.
REQ-038 SHALL cover disabled channel and saturation: ch_en=FE, 300 words to dest=0 -> out_valid never set, drop_cnt climbs to 255, holds 255.
REQ-039 SHALL cover reset mid-HOLD: word to dest=2 held, rst_n low between clock edges -> out_valid=00, drop_cnt=00 immediately; in_ready=1 after release.
